// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory address and captures the returned word into the IF/ID register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT = 32'd44,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    input  logic [31:0]      instr_i,
    output logic [31:0]      pc_addr_o,
    output logic [31:0]      ifid_pc_plus4_o,
    output logic [31:0]      ifid_instr_o,
    output logic             ifid_valid_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] fetch_count_o
);

    localparam logic STATE_RUN  = 1'b0;
    localparam logic STATE_HALT = 1'b1;
    localparam logic STATE_INIT = (RESET_PC < PC_LIMIT) ? STATE_RUN : STATE_HALT;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic [31:0]      ifid_instr_q, ifid_instr_d;
    logic             ifid_valid_q, ifid_valid_d;
    logic             state_q, state_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;

    assign pc_plus4        = pc_q + 32'd4;
    assign redirect_target = {redirect_pc_i[31:2], 2'b00};

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path
        // through this block can infer a latch.
        pc_d            = pc_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        ifid_instr_d    = ifid_instr_q;
        ifid_valid_d    = ifid_valid_q;
        state_d         = state_q;
        fetch_count_d   = fetch_count_q;

        if (redirect_i) begin
            // Flush the wrong-path fetch; the counter only tracks real captures.
            pc_d            = redirect_target;
            ifid_pc_plus4_d = 32'd0;
            ifid_instr_d    = 32'd0;
            ifid_valid_d    = 1'b0;
            state_d         = (redirect_target < PC_LIMIT) ? STATE_RUN : STATE_HALT;
        end else if (stall_i) begin
            // Hold everything; IF/ID is re-presented to decode unchanged.
        end else if (state_q == STATE_RUN) begin
            pc_d            = pc_plus4;
            ifid_pc_plus4_d = pc_plus4;
            ifid_instr_d    = instr_i;
            ifid_valid_d    = 1'b1;
            if (fetch_count_q != CNT_MAX) begin
                fetch_count_d = fetch_count_q + CNT_ONE;
            end
            if (pc_plus4 >= PC_LIMIT) begin
                state_d = STATE_HALT;
            end
        end else begin
            // Halted: instr_i is never sampled, so an undriven memory cannot leak X.
            ifid_pc_plus4_d = 32'd0;
            ifid_instr_d    = 32'd0;
            ifid_valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q            <= RESET_PC;
            ifid_pc_plus4_q <= 32'd0;
            ifid_instr_q    <= 32'd0;
            ifid_valid_q    <= 1'b0;
            state_q         <= STATE_INIT;
            fetch_count_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the
            // same pre-edge values, independent of statement order.
            pc_q            <= pc_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_valid_q    <= ifid_valid_d;
            state_q         <= state_d;
            fetch_count_q   <= fetch_count_d;
        end
    end

    assign pc_addr_o       = pc_q;
    assign ifid_pc_plus4_o = ifid_pc_plus4_q;
    assign ifid_instr_o    = ifid_instr_q;
    assign ifid_valid_o    = ifid_valid_q;
    assign halted_o        = (state_q == STATE_HALT);
    assign fetch_count_o   = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a behavioural fetch model checked every
// cycle, directed scenarios with literal expectations, and a saturation instance.
module tb_if_stage;

    localparam logic [31:0] LIMIT = 32'd44;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] pc_addr;
    logic [31:0] ifid_pc_plus4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic        rst_sat_n;
    logic [31:0] sat_pc_addr, sat_pc_plus4, sat_instr_q;
    logic        sat_valid, sat_halted;
    logic [3:0]  sat_count;

    int tests_run = 0;
    int tests_failed = 0;
    bit armed = 0;
    bit sat_done = 0;

    // Memory image: word at address A is 0x1000_0000 + A; undriven while halted.
    assign instr = halted ? 32'hxxxx_xxxx : 32'h1000_0000 + pc_addr;

    if_stage dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .stall_i        (stall),
        .redirect_i     (redirect),
        .redirect_pc_i  (redirect_pc),
        .instr_i        (instr),
        .pc_addr_o      (pc_addr),
        .ifid_pc_plus4_o(ifid_pc_plus4),
        .ifid_instr_o   (ifid_instr),
        .ifid_valid_o   (ifid_valid),
        .halted_o       (halted),
        .fetch_count_o  (fetch_count)
    );

    if_stage #(.RESET_PC(32'h0), .PC_LIMIT(32'h100), .CNT_W(4)) dut_sat (
        .clk_i          (clk),
        .rst_i          (rst_sat_n),
        .stall_i        (1'b0),
        .redirect_i     (1'b0),
        .redirect_pc_i  (32'h0),
        .instr_i        (32'hABCD_0000),
        .pc_addr_o      (sat_pc_addr),
        .ifid_pc_plus4_o(sat_pc_plus4),
        .ifid_instr_o   (sat_instr_q),
        .ifid_valid_o   (sat_valid),
        .halted_o       (sat_halted),
        .fetch_count_o  (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: the fetcher is halted exactly when its PC lies at or
    // beyond the image end, so no explicit state is kept.
    logic [31:0] m_pc, m_pp4, m_instr;
    logic        m_valid;
    int          m_count;

    function automatic bit m_halted();
        return m_pc >= LIMIT;
    endfunction

    task automatic model_reset();
        m_pc = 32'd0; m_pp4 = 32'd0; m_instr = 32'd0; m_valid = 1'b0; m_count = 0;
    endtask

    initial model_reset();
    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (rst_n) begin
            if (redirect) begin
                m_pc = redirect_pc & 32'hFFFF_FFFC;
                m_pp4 = 0; m_instr = 0; m_valid = 0;
            end else if (stall) begin
            end else if (!m_halted()) begin
                m_pp4 = m_pc + 4; m_instr = 32'h1000_0000 + m_pc; m_valid = 1;
                m_pc = m_pc + 4;
                if (m_count < 65535) m_count++;
            end else begin
                m_pp4 = 0; m_instr = 0; m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("model pc_addr", pc_addr, m_pc);
            check("model ifid_pc_plus4", ifid_pc_plus4, m_pp4);
            check("model ifid_instr", ifid_instr, m_instr);
            check("model ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
            check("model halted", {31'd0, halted}, {31'd0, m_halted()});
            check("model fetch_count", {16'd0, fetch_count}, m_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Saturation instance: 4-bit counter must count 1..15 then stick at 15.
    initial begin
        rst_sat_n = 1'b0;
        #12 rst_sat_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #2;
            check($sformatf("sat count edge %0d", k), {28'd0, sat_count}, (k < 15) ? k : 15);
        end
        sat_done = 1;
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        #1 armed = 1;
        #1;
        check("reset pc", pc_addr, 32'd0);
        check("reset valid", {31'd0, ifid_valid}, 32'd0);
        check("reset count", {16'd0, fetch_count}, 32'd0);
        check("reset halted", {31'd0, halted}, 32'd0);
        #10 rst_n = 1'b1;

        // Straight-line fetch to the end of the image
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 1) begin
                check("edge1 instr", ifid_instr, 32'h1000_0000);
                check("edge1 pc_plus4", ifid_pc_plus4, 32'd4);
                check("edge1 valid", {31'd0, ifid_valid}, 32'd1);
            end
            if (e == 11) begin
                check("edge11 pc", pc_addr, 32'd44);
                check("edge11 halted", {31'd0, halted}, 32'd1);
                check("edge11 count", {16'd0, fetch_count}, 32'd11);
                check("edge11 instr", ifid_instr, 32'h1000_0028);
            end
            if (e == 12) begin
                check("edge12 valid", {31'd0, ifid_valid}, 32'd0);
                check("edge12 pc frozen", pc_addr, 32'd44);
            end
        end

        // Redirect out of HALT back into the image
        redirect = 1'b1; redirect_pc = 32'h8;
        tick();
        redirect = 1'b0;
        check("redir8 halted", {31'd0, halted}, 32'd0);
        check("redir8 pc", pc_addr, 32'd8);
        check("redir8 bubble", {31'd0, ifid_valid}, 32'd0);
        check("redir8 count held", {16'd0, fetch_count}, 32'd11);
        tick();
        check("after redir8 pc_plus4", ifid_pc_plus4, 32'd12);
        check("after redir8 count", {16'd0, fetch_count}, 32'd12);

        // Redirect beyond the image keeps the fetcher halted
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        check("redir40 halted", {31'd0, halted}, 32'd1);
        check("redir40 pc", pc_addr, 32'h40);
        tick();
        redirect = 1'b0;
        check("redir40 from halt halted", {31'd0, halted}, 32'd1);
        check("redir40 from halt pc", pc_addr, 32'h40);
        tick();
        check("halt holds pc", pc_addr, 32'h40);
        check("halt bubble instr", ifid_instr, 32'd0);

        // Stall with PC=8 after capturing the word at 4
        redirect = 1'b1; redirect_pc = 32'h4;
        tick();
        redirect = 1'b0;
        tick();
        check("pre-stall pc", pc_addr, 32'd8);
        stall = 1'b1;
        for (int s = 0; s < 2; s++) begin
            tick();
            check("stall pc", pc_addr, 32'd8);
            check("stall pc_plus4", ifid_pc_plus4, 32'd8);
            check("stall count", {16'd0, fetch_count}, 32'd13);
        end
        stall = 1'b0;
        tick();
        check("post-stall pc_plus4", ifid_pc_plus4, 32'd12);
        check("post-stall pc", pc_addr, 32'd12);

        // Redirect beats a simultaneous stall, target forced to word alignment
        tick(); tick();
        check("pre-redir pc", pc_addr, 32'd20);
        redirect = 1'b1; redirect_pc = 32'h6; stall = 1'b1;
        tick();
        redirect = 1'b0; stall = 1'b0;
        check("redir+stall pc", pc_addr, 32'd4);
        check("redir+stall valid", {31'd0, ifid_valid}, 32'd0);
        check("redir+stall halted", {31'd0, halted}, 32'd0);

        // Asynchronous reset between edges
        for (int t = 0; t < 6; t++) tick();
        check("pre-reset pc", pc_addr, 32'd28);
        rst_n = 1'b0;
        #1;
        check("async reset pc", pc_addr, 32'd0);
        check("async reset valid", {31'd0, ifid_valid}, 32'd0);
        check("async reset count", {16'd0, fetch_count}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("post-reset pc_plus4", ifid_pc_plus4, 32'd4);
        check("post-reset count", {16'd0, fetch_count}, 32'd1);

        for (int w = 0; w < 50 && !sat_done; w++) tick();
        check("saturation run completed", {31'd0, sat_done}, 32'd1);

        armed = 0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined CPU.
- Owns the program counter and drives the fetch address into the combinational instruction memory.
- Captures the returned word into the IF/ID pipeline register.
- Handles load-use stalls and branch redirects from later stages, halts fetch at the end of the loaded program image, and keeps a fetch counter for bench statistics.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_LIMIT, 32'd44, first byte address past the program image (11 words); fetch halts on reaching it
CNT_W, 16, width of the fetch counter

Ports:
clk_i  input  1  clock; all state updates on its rising edge
rst_i  input  1  reset; asynchronous, active-low
stall_i  input  1  hazard unit hold request (load-use)
redirect_i  input  1  taken branch/jump resolved downstream
redirect_pc_i  input  32  redirect target byte address
instr_i  input  32  instruction word returned by instruction memory for pc_addr_o
pc_addr_o  output  32  fetch byte address to instruction memory (current PC register)
ifid_pc_plus4_o  output  32  IF/ID: PC+4 of the captured instruction
ifid_instr_o  output  32  IF/ID: captured instruction
ifid_valid_o  output  1  IF/ID: 1 = real instruction, 0 = bubble
halted_o  output  1  1 while the FSM is in HALT
fetch_count_o  output  CNT_W  number of instructions captured into IF/ID, saturating

Behaviour:
- Reset (rst_i=0, asynchronous):
  - PC=RESET_PC; IF/ID is a bubble (pc_plus4=0, instr=0, valid=0); fetch_count=0.
  - FSM=RUN if RESET_PC<PC_LIMIT, otherwise HALT.
- Reset mid-operation discards all state immediately, without waiting for a clock edge.
- Outputs are direct register values. pc_addr_o=PC. Memory is combinational, so instr_i is valid in the same cycle.
- FSM states:
  - RUN: fetching.
  - HALT: PC frozen, bubbles injected.
  - halted_o=(state==HALT).
- Per-edge priority: redirect_i > stall_i > state action.
- Redirect (regardless of stall_i or state):
  - PC <= {redirect_pc_i[31:2],2'b00}, forced word alignment.
  - IF/ID <= bubble, flushing the wrong-path fetch.
  - State <= RUN if the aligned target < PC_LIMIT, else HALT.
  - Counter unchanged.
- Stall (no redirect): PC, IF/ID, state and counter all hold. The IF/ID contents are re-presented unchanged.
- RUN, no stall, no redirect:
  - IF/ID <= {PC+4, instr_i, valid=1}; PC <= PC+4.
  - fetch_count += 1, saturating at all-ones.
  - If PC+4 >= PC_LIMIT, state <= HALT. The last in-range instruction is still captured on this edge.
- HALT, no stall, no redirect: PC holds; IF/ID <= bubble; counter holds.
- Arithmetic rules:
  - PC+4 is modulo 2^32; a wrap to 0 is permitted only if PC_LIMIT > 0xFFFFFFFC.
  - All limit comparisons are unsigned.
- Fetch latency: an instruction at address A appears on ifid_* one edge after pc_addr_o==A with no stall.
- No X on any output after reset, even if instr_i is X while in HALT.

Test Plan:
- Straight-line fetch, defaults, instr_i = 0x1000_0000 + address:
  - Release reset and run 12 edges.
  - Edge 1: ifid_instr=0x1000_0000, pc_plus4=4, valid=1.
  - Edge 11: pc_addr_o=44, halted_o=1, fetch_count=11.
  - Edge 12: valid=0.
- Stall:
  - Assert stall_i for 2 cycles with PC=8.
  - PC stays 8 and ifid_pc_plus4 stays 8 for both cycles; count unchanged.
  - Next edge: ifid_pc_plus4=12, pc_addr_o=12.
- Redirect plus simultaneous stall:
  - At PC=20, assert redirect_i=1, redirect_pc_i=0x0000_0006, stall_i=1.
  - Next edge: pc_addr_o=4 (aligned), valid=0, halted_o=0.
- Redirect out of HALT:
  - After halt, redirect to 0x8.
  - halted_o=0 and PC=8; the next fetch captures pc_plus4=12.
  - A redirect to 0x40 instead keeps halted_o=1 with PC=0x40.
- Asynchronous reset mid-run:
  - Drop rst_i between edges at PC=28.
  - Without waiting for an edge: pc_addr_o=0, valid=0, fetch_count=0.
  - First edge after release: pc_plus4=4.
- Counter saturation, CNT_W=4, PC_LIMIT=32'h100:
  - Run 20 fetches.
  - fetch_count_o sticks at 15.
